// File: rtl/sync_strobe_gen_pkg.sv
// ----------------------------------------------------------------------------
// sync_defs
//   Shared definitions for the epoch strobe generator.
//   - state_e : FSM state encoding, also driven out on the 2-bit state port
//               (0 IDLE, 1 ARMED, 2 RUN).
//   - EPOCH_W : width of the wrapping epoch counter.
// ----------------------------------------------------------------------------
package sync_defs;

    localparam int unsigned EPOCH_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/sync_strobe_gen_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det
//   Synchroniser and polarity-selectable edge detector for the asynchronous
//   external sync input.
//
//   Ports
//     clk     in   system clock, posedge
//     reset   in   asynchronous active-low reset
//     sync_i  in   asynchronous external sync level
//     pol_i   in   1 = rising edge active, 0 = falling edge active
//     edge_o  out  registered one-cycle pulse on the active transition
//
//   Latency: a transition first sampled at clock edge k produces edge_o high
//   after edge k+SYNC_STAGES, so a consumer acts on it at edge k+SYNC_STAGES+1.
//   SYNC_STAGES must be at least 2.
// ----------------------------------------------------------------------------
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_i,
    input  logic pol_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_q;
    logic                   edge_d;

    // Compare the synchronised level against the one-cycle-old history flop.
    always_comb begin
        edge_d = 1'b0;
        if (pol_i) begin
            edge_d = sync_q[SYNC_STAGES-1] & ~hist_q;
        end else begin
            edge_d = ~sync_q[SYNC_STAGES-1] & hist_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sync_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            edge_q <= edge_d;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/sync_strobe_gen.sv
// ----------------------------------------------------------------------------
// sync_strobe_gen
//   Epoch / time-mark strobe generator. Aligns a free-running counter to an
//   external sync edge with a programmable phase, then emits a one-clock
//   strobe every period+1 clocks for the downstream delay line.
//
//   Ports
//     clk        in   system clock, posedge
//     reset      in   asynchronous active-low reset
//     enable     in   block enable; low forces IDLE on the next clock
//     arm        in   one-clock (re)arm pulse; waits for next sync edge
//     sync_pol   in   1 = rising, 0 = falling ext_sync edge is active
//     ext_sync   in   asynchronous external sync input
//     period     in   strobe interval minus one
//     phase      in   counter load value on the sync edge
//     strobe     out  registered one-clock epoch strobe
//     epoch_cnt  out  strobes since last arm, wraps mod 2^16
//     state      out  FSM state (0 IDLE, 1 ARMED, 2 RUN)
//     slip       out  sticky: sync edge seen in RUN while counter != 0
// ----------------------------------------------------------------------------
module sync_strobe_gen
    import sync_defs::*;
#(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 arm,
    input  logic                 sync_pol,
    input  logic                 ext_sync,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] phase,
    output logic                 strobe,
    output logic [EPOCH_W-1:0]   epoch_cnt,
    output logic [1:0]           state,
    output logic                 slip
);

    logic                 sync_edge;

    state_e               state_q,      state_d;
    logic [CNT_WIDTH-1:0] counter_q,    counter_d;
    logic [CNT_WIDTH-1:0] period_lat_q, period_lat_d;
    logic                 strobe_q,     strobe_d;
    logic [EPOCH_W-1:0]   epoch_q,      epoch_d;
    logic                 slip_q,       slip_d;
    logic                 at_wrap;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_det (
        .clk    (clk),
        .reset  (reset),
        .sync_i (ext_sync),
        .pol_i  (sync_pol),
        .edge_o (sync_edge)
    );

    assign at_wrap = (counter_q == period_lat_q);

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        period_lat_d = period_lat_q;
        strobe_d     = 1'b0;
        epoch_d      = epoch_q;
        slip_d       = slip_q;

        if (!enable) begin
            // Disable wins from any state; epoch_cnt and slip are kept.
            state_d   = ST_IDLE;
            counter_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    counter_d = '0;
                    if (arm) begin
                        state_d = ST_ARMED;
                        epoch_d = '0;
                        slip_d  = 1'b0;
                    end
                end

                ST_ARMED: begin
                    // A re-arm coinciding with the sync edge discards the edge.
                    if (arm) begin
                        epoch_d = '0;
                        slip_d  = 1'b0;
                    end else if (sync_edge) begin
                        state_d      = ST_RUN;
                        counter_d    = (phase > period) ? '0 : phase;
                        period_lat_d = period;
                    end
                end

                ST_RUN: begin
                    strobe_d = at_wrap;
                    // The shadow period is only refreshed at the wrap so the
                    // epoch in flight keeps its length.
                    if (at_wrap) begin
                        counter_d    = '0;
                        period_lat_d = period;
                    end else begin
                        counter_d = counter_q + CNT_WIDTH'(1);
                    end
                    epoch_d = epoch_q + EPOCH_W'(strobe_d);
                    // A later sync edge only flags misalignment; the counter
                    // is never re-aligned while running.
                    if (sync_edge && (counter_q != '0)) begin
                        slip_d = 1'b1;
                    end
                    if (arm) begin
                        state_d   = ST_ARMED;
                        counter_d = '0;
                        epoch_d   = '0;
                        slip_d    = 1'b0;
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    counter_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            period_lat_q <= '0;
            strobe_q     <= 1'b0;
            epoch_q      <= '0;
            slip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            period_lat_q <= period_lat_d;
            strobe_q     <= strobe_d;
            epoch_q      <= epoch_d;
            slip_q       <= slip_d;
        end
    end

    assign strobe    = strobe_q;
    assign epoch_cnt = epoch_q;
    assign state     = state_q;
    assign slip      = slip_q;

endmodule
